// File: rtl/lzx_enc_pkg.sv
// Shared types and constants for the 4-to-2 sequential request encoder.
package lzx_enc_pkg;

  localparam int LZX_NREQ  = 4;
  localparam int LZX_CODEW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  function automatic logic multi_req(input logic [LZX_NREQ-1:0] req);
    int cnt;
    cnt = 0;
    for (int i = 0; i < LZX_NREQ; i++) begin
      cnt = cnt + int'(req[i]);
    end
    return cnt > 1;
  endfunction

endpackage

// File: rtl/lzx_prio_pick.sv
// Combinational picker: first set request at or after ptr, searching cyclically.
// With ptr tied to 0 this is plain lowest-index-wins priority.
module lzx_prio_pick
  import lzx_enc_pkg::*;
(
  input  logic [LZX_NREQ-1:0]  pend,
  input  logic [LZX_CODEW-1:0] ptr,
  output logic [LZX_CODEW-1:0] idx,
  output logic                 any
);

  logic [LZX_CODEW-1:0] cand;

  // Scan from the farthest offset down so the nearest hit is the one kept.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = LZX_NREQ - 1; k >= 0; k--) begin
      cand = ptr + LZX_CODEW'(k);
      if (pend[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lzx_encoder4x2_seq.sv
// Captures active-low requests and issues one registered 2-bit code per request under valid/ack.
// Define LZX_ENC_RR_EN for round-robin pick order; otherwise lowest index wins.
module lzx_encoder4x2_seq
  import lzx_enc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [LZX_NREQ-1:0] y,
  input  logic                ack,
  output logic                a,
  output logic                b,
  output logic                valid,
  output logic                multi
);

  state_t               state_q, state_d;
  logic [LZX_NREQ-1:0]  pend_q, pend_d;
  logic [LZX_CODEW-1:0] code_q, code_d;
  logic                 valid_q, valid_d;
  logic                 multi_q, multi_d;

  logic [LZX_NREQ-1:0]  pend_clr;
  logic [LZX_NREQ-1:0]  pick_in;
  logic [LZX_CODEW-1:0] pick_ptr;
  logic [LZX_CODEW-1:0] pick_idx;
  logic                 pick_any;

`ifdef LZX_ENC_RR_EN
  logic [LZX_CODEW-1:0] ptr_q, ptr_d;

  // After an ack the search resumes just past the index being granted now.
  assign pick_ptr = (state_q == SERVE) ? code_q + 1'b1 : ptr_q;
`else
  assign pick_ptr = '0;
`endif

  assign pend_clr = pend_q & ~(LZX_NREQ'(1) << code_q);
  assign pick_in  = (state_q == IDLE) ? ~y : pend_clr;

  lzx_prio_pick u_pick (
    .pend (pick_in),
    .ptr  (pick_ptr),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    code_d  = code_q;
    valid_d = valid_q;
    multi_d = multi_q;
`ifdef LZX_ENC_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (en && (~y != '0)) begin
          pend_d  = ~y;
          multi_d = multi_req(~y);
          code_d  = pick_idx;
          valid_d = 1'b1;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (!en) begin
          pend_d  = '0;
          multi_d = 1'b0;
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (ack) begin
          pend_d = pend_clr;
`ifdef LZX_ENC_RR_EN
          ptr_d  = code_q + 1'b1;
`endif
          if (pick_any) begin
            code_d = pick_idx;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
`ifdef LZX_ENC_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
`ifdef LZX_ENC_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign a     = code_q[1];
  assign b     = code_q[0];
  assign valid = valid_q;
  assign multi = multi_q;

endmodule
